inst_fetch_unit: RTL
====================

# inst_fetch_unit

Instruction fetch stage for the single-cycle RV32I core. Owns the program counter and drives the combinational instruction memory address. Buffers fetched words in a 2-entry prefetch queue, then hands {PC, instruction} to the decode/execute stage over a valid/ready handshake. Supports a one-cycle redirect (branch/jump) that flushes the queue and restarts fetch at a new address.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; low two bits must be zero.
- NOP_INST, 32'h0000_0013: value driven on OUT_INST while the queue is empty (addi x0,x0,0).

- CLK  in  1  single clock; all state updates on posedge CLK.
- RST  in  1  reset, synchronous, active-high.
- IMEM_ADDR  out  32  byte address to instruction memory; equals current fetch PC.
- IMEM_INST  in  32  instruction word; combinational response to IMEM_ADDR in the same cycle.
- REDIRECT  in  1  pulse: discard queue, restart fetch at REDIRECT_PC.
- REDIRECT_PC  in  32  redirect target; bits [1:0] ignored (forced to 0).
- OUT_VALID  out  1  queue head holds a valid instruction.
- OUT_READY  in  1  consumer accepts the head this cycle.
- OUT_INST  out  32  head instruction word; NOP_INST when empty.
- OUT_PC  out  32  PC of head instruction; 0 when empty.
- FETCH_COUNT  out  32  number of completed handshakes since reset; wraps mod 2^32.

## Operation
- State: fetch PC register (pc), 2-entry FIFO of {pc, inst}, occupancy count in {0,1,2}, FETCH_COUNT register.
- Occupancy states: EMPTY (0), ONE (1), FULL (2).
- pop = OUT_VALID & OUT_READY.
- push = !REDIRECT & (count < 2 | pop). A push writes {pc, IMEM_INST} at the tail and sets pc <= pc + 4.
- Transitions without redirect:
  - push & !pop: count+1.
  - pop & !push: count-1.
  - push & pop: count unchanged; FULL stays FULL.
- Queue is strictly in order. OUT_INST and OUT_PC always reflect the head entry.
- Redirect:
  - Sets count <= 0 and pc <= {REDIRECT_PC[31:2], 2'b00}.
  - No push in that cycle.
  - A pop coinciding with REDIRECT is honoured: the head counts as delivered and FETCH_COUNT increments. All other entries are discarded.
- PC arithmetic is 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- FETCH_COUNT increments by 1 on every pop.
- RST has priority over REDIRECT and over the handshake.

## Timing
- Reset values: pc = RESET_PC, count = 0, OUT_VALID = 0, OUT_INST = NOP_INST, OUT_PC = 0, FETCH_COUNT = 0, IMEM_ADDR = RESET_PC.
- Memory is read combinationally during cycle N and captured at the end of cycle N.
- Latency from fetch to output is 1 cycle:
  - First cycle after RST deasserts: fetch RESET_PC.
  - OUT_VALID = 1 in the following cycle.
- With OUT_READY held at 1, throughput is one instruction per cycle and count stays at 1.
- Backpressure: with OUT_READY = 0, the queue fills in at most 2 cycles. After that, pc and IMEM_ADDR hold, and OUT_INST/OUT_PC are stable until pop.
- Redirect latency:
  - Cycle after REDIRECT: OUT_VALID = 0 and IMEM_ADDR = target.
  - One cycle later: OUT_VALID = 1 with OUT_PC = target.
- Back-to-back REDIRECT pulses: the last one wins. OUT_VALID stays 0 until one cycle after the final pulse.
- RST asserted mid-stream: next cycle all state equals reset values; queued entries are lost.
- OUT_VALID depends only on registered state, never combinationally on OUT_READY.

## Test plan
- Streaming:
  - Stimulus: memory word at addr A = A ^ 32'hA5A5_0000, RESET_PC = 0, OUT_READY = 1.
  - Response: OUT_VALID = 0 in the first cycle after reset. Then OUT_PC = 0, 4, 8, 12 on consecutive cycles with matching OUT_INST. FETCH_COUNT = 4 after 4 transfers.
- Backpressure:
  - Stimulus: OUT_READY = 0 for 5 cycles after the first valid, then 1.
  - Response: count reaches 2. IMEM_ADDR holds at 8. OUT_PC holds at 0 for 5 cycles. After release, OUT_PC = 0, 4, 8, 12 with no gap and no duplicate.
- Redirect with full queue:
  - Stimulus: REDIRECT = 1 with REDIRECT_PC = 32'h0000_0043 and OUT_READY = 1.
  - Response: the head popped in that cycle is counted. Next cycle OUT_VALID = 0 and IMEM_ADDR = 32'h40. The cycle after, OUT_PC = 32'h40, then 32'h44.
- PC wrap:
  - Stimulus: RESET_PC = 32'hFFFF_FFF8, OUT_READY = 1.
  - Response: OUT_PC sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset mid-operation:
  - Stimulus: assert RST for 1 cycle while count = 2 and REDIRECT = 1.
  - Response: next cycle OUT_VALID = 0, OUT_INST = 32'h13, FETCH_COUNT = 0, IMEM_ADDR = RESET_PC. The redirect target is ignored.
- Back-to-back redirects:
  - Stimulus: REDIRECT pulses to 32'h100 then 32'h200 in consecutive cycles.
  - Response: no instruction from 32'h100 is ever presented. First valid OUT_PC is 32'h200.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory combinationally,
// buffers fetched words in a 2-entry in-order queue and hands {pc, inst} downstream.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_INST,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_INST,
    output logic [31:0] OUT_PC,
    output logic [31:0] FETCH_COUNT
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t            occ;
    logic [XLEN-1:0] pc;
    logic            head_valid;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_inst;
    logic [XLEN-1:0] tail_pc;
    logic [XLEN-1:0] tail_inst;
    logic [XLEN-1:0] fetch_count;

    logic            pop;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] redirect_target;

    assign pop             = head_valid & OUT_READY;
    assign pc_next         = pc + XLEN'(4);
    assign redirect_target = REDIRECT_PC & ~XLEN'(3);

    // Head entry lives in dedicated registers so the output port is a flop, not a mux.
    always_ff @(posedge CLK) begin
        if (RST) begin
            occ         <= EMPTY;
            pc          <= RESET_PC;
            head_valid  <= 1'b0;
            head_pc     <= '0;
            head_inst   <= NOP_INST;
            tail_pc     <= '0;
            tail_inst   <= NOP_INST;
            fetch_count <= '0;
        end else begin
            if (pop) begin
                fetch_count <= fetch_count + XLEN'(1);
            end
            if (REDIRECT) begin
                // A coinciding pop was already counted above; everything else is dropped.
                occ        <= EMPTY;
                pc         <= redirect_target;
                head_valid <= 1'b0;
                head_pc    <= '0;
                head_inst  <= NOP_INST;
            end else begin
                case (occ)
                    EMPTY: begin
                        head_valid <= 1'b1;
                        head_pc    <= pc;
                        head_inst  <= IMEM_INST;
                        pc         <= pc_next;
                        occ        <= ONE;
                    end
                    ONE: begin
                        pc <= pc_next;
                        if (pop) begin
                            head_pc   <= pc;
                            head_inst <= IMEM_INST;
                        end else begin
                            tail_pc   <= pc;
                            tail_inst <= IMEM_INST;
                            occ       <= FULL;
                        end
                    end
                    FULL: begin
                        // Only fetch when the head drains; otherwise pc and the queue hold.
                        if (pop) begin
                            head_pc   <= tail_pc;
                            head_inst <= tail_inst;
                            tail_pc   <= pc;
                            tail_inst <= IMEM_INST;
                            pc        <= pc_next;
                        end
                    end
                    default: begin
                        occ <= EMPTY;
                    end
                endcase
            end
        end
    end

    assign IMEM_ADDR   = pc;
    assign OUT_VALID   = head_valid;
    assign OUT_INST    = head_inst;
    assign OUT_PC      = head_pc;
    assign FETCH_COUNT = fetch_count;

endmodule
